// File: rtl/lsu_pkg.sv
// Shared encodings for the EXU load/store unit: access sizes, FSM states and
// the size-to-byte-mask helper.
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } lsu_state_e;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      SIZE_B:  size_mask = 8'h01;
      SIZE_H:  size_mask = 8'h03;
      SIZE_W:  size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/exu_lsu_if.sv
// EXU request / memory port / WBU response bundle for the load/store unit.
// The slave modport is the LSU itself; master is the surrounding pipeline+memory.
interface exu_lsu_if #(
  parameter int ISA_WIDTH = 32
);
  localparam int STRB_W = ISA_WIDTH / 8;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [1:0]           req_size;
  logic                 req_unsigned;
  logic [ISA_WIDTH-1:0] req_addr;
  logic [ISA_WIDTH-1:0] req_wdata;

  logic                 mem_valid;
  logic                 mem_ready;
  logic                 mem_we;
  logic [ISA_WIDTH-1:0] mem_addr;
  logic [ISA_WIDTH-1:0] mem_wdata;
  logic [STRB_W-1:0]    mem_wstrb;
  logic                 mem_rvalid;
  logic [ISA_WIDTH-1:0] mem_rdata;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ISA_WIDTH-1:0] rsp_data;
  logic                 rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rvalid, mem_rdata,
    input  rsp_valid, rsp_data, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rvalid, mem_rdata,
    output rsp_valid, rsp_data, rsp_err,
    input  rsp_ready
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane math: store strobes/shift, load extract + extend,
// and the misalignment / illegal-size flag.
module lsu_align
  import lsu_pkg::*;
#(
  parameter  int ISA_WIDTH = 32,
  localparam int STRB_W    = ISA_WIDTH / 8,
  localparam int OFF_W     = $clog2(ISA_WIDTH / 8)
) (
  input  logic [1:0]           i_size,
  input  logic                 i_unsigned,
  input  logic [OFF_W-1:0]     i_off,
  input  logic [ISA_WIDTH-1:0] i_wdata,
  input  logic [ISA_WIDTH-1:0] i_rdata,
  output logic [STRB_W-1:0]    o_wstrb,
  output logic [ISA_WIDTH-1:0] o_wdata,
  output logic [ISA_WIDTH-1:0] o_rdata,
  output logic                 o_misalign
);

  logic [7:0]           w_mask8;
  logic [OFF_W-1:0]     w_low;
  logic [ISA_WIDTH-1:0] w_shifted;
  logic [ISA_WIDTH-1:0] w_keep;
  logic                 w_sign;

  always_comb begin
    w_mask8    = size_mask(i_size);
    w_low      = OFF_W'((8'd1 << i_size) - 8'd1);
    o_misalign = ((i_size == SIZE_D) && (ISA_WIDTH != 64)) || ((i_off & w_low) != '0);
    o_wstrb    = STRB_W'({8'h00, w_mask8} << i_off);
    o_wdata    = i_wdata << {i_off, 3'b000};
    w_shifted  = i_rdata >> {i_off, 3'b000};
    // Expand the byte mask to a bit mask; bits outside it take the sign (or zero).
    w_keep = '0;
    for (int unsigned i = 0; i < STRB_W; i++) begin
      w_keep[8*i +: 8] = {8{w_mask8[i]}};
    end
    case (i_size)
      SIZE_B:  w_sign = w_shifted[7];
      SIZE_H:  w_sign = w_shifted[15];
      SIZE_W:  w_sign = w_shifted[31];
      default: w_sign = w_shifted[ISA_WIDTH-1];
    endcase
    o_rdata = (w_shifted & w_keep) | ({ISA_WIDTH{w_sign & ~i_unsigned}} & ~w_keep);
  end

endmodule

// File: rtl/exu_lsu.sv
// EXU load/store unit: one outstanding op, IDLE->REQ->WAIT->RESP handshake FSM
// with registered outputs; lane math lives in lsu_align.
module exu_lsu
  import lsu_pkg::*;
#(
  parameter  int ISA_WIDTH = 32,
  localparam int STRB_W    = ISA_WIDTH / 8,
  localparam int OFF_W     = $clog2(ISA_WIDTH / 8)
) (
  input logic      clk,
  input logic      rst,
  exu_lsu_if.slave bus
);

  lsu_state_e           r_state;
  logic                 r_req_ready;
  logic                 r_mem_valid;
  logic                 r_rsp_valid;
  logic                 r_rsp_err;
  logic                 r_we;
  logic                 r_unsigned;
  logic [1:0]           r_size;
  logic [ISA_WIDTH-1:0] r_addr;
  logic [ISA_WIDTH-1:0] r_mem_wdata;
  logic [STRB_W-1:0]    r_mem_wstrb;
  logic [ISA_WIDTH-1:0] r_rsp_data;

  logic [1:0]           w_size;
  logic                 w_unsigned;
  logic [OFF_W-1:0]     w_off;
  logic [STRB_W-1:0]    w_wstrb;
  logic [ISA_WIDTH-1:0] w_wdata;
  logic [ISA_WIDTH-1:0] w_rdata;
  logic                 w_misalign;

  // One aligner serves the live request while idle and the captured op afterwards.
  always_comb begin
    if (r_state == IDLE) begin
      w_size     = bus.req_size;
      w_unsigned = bus.req_unsigned;
      w_off      = bus.req_addr[OFF_W-1:0];
    end else begin
      w_size     = r_size;
      w_unsigned = r_unsigned;
      w_off      = r_addr[OFF_W-1:0];
    end
  end

  lsu_align #(.ISA_WIDTH(ISA_WIDTH)) u_align (
    .i_size    (w_size),
    .i_unsigned(w_unsigned),
    .i_off     (w_off),
    .i_wdata   (bus.req_wdata),
    .i_rdata   (bus.mem_rdata),
    .o_wstrb   (w_wstrb),
    .o_wdata   (w_wdata),
    .o_rdata   (w_rdata),
    .o_misalign(w_misalign)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b1;
      r_mem_valid <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_we        <= 1'b0;
      r_unsigned  <= 1'b0;
      r_size      <= '0;
      r_addr      <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.req_valid) begin
          r_we        <= bus.req_we;
          r_size      <= bus.req_size;
          r_unsigned  <= bus.req_unsigned;
          r_addr      <= bus.req_addr;
          r_mem_wdata <= w_wdata;
          r_mem_wstrb <= bus.req_we ? w_wstrb : '0;
          r_req_ready <= 1'b0;
          if (w_misalign) begin
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_mem_valid <= 1'b1;
            r_state     <= REQ;
          end
        end
        REQ: if (bus.mem_ready) begin
          r_mem_valid <= 1'b0;
          r_state     <= WAIT;
        end
        WAIT: if (bus.mem_rvalid) begin
          r_rsp_data  <= r_we ? '0 : w_rdata;
          r_rsp_err   <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.mem_valid = r_mem_valid;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = {r_addr[ISA_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_wstrb = r_mem_wstrb;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_exu_lsu.sv
// Randomized bench for exu_lsu: drives a 32-bit and a 64-bit instance through one
// shared stimulus path and checks every cycle against a transaction-level model.
module tb_exu_lsu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exu_lsu_if #(.ISA_WIDTH(32)) if32 ();
  exu_lsu_if #(.ISA_WIDTH(64)) if64 ();

  exu_lsu #(.ISA_WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));
  exu_lsu #(.ISA_WIDTH(64)) dut64 (.clk(clk), .rst(rst), .bus(if64));

  logic        sel = 1'b0;
  logic        d_req_valid = 1'b0, d_we = 1'b0, d_uns = 1'b0;
  logic [1:0]  d_size = 2'd0;
  logic [63:0] d_addr = '0, d_wdata = '0, d_rdata = '0;
  logic        d_mem_ready = 1'b0, d_rvalid = 1'b0, d_rsp_ready = 1'b0;

  assign if32.req_valid    = d_req_valid & ~sel;
  assign if32.req_we       = d_we;
  assign if32.req_size     = d_size;
  assign if32.req_unsigned = d_uns;
  assign if32.req_addr     = d_addr[31:0];
  assign if32.req_wdata    = d_wdata[31:0];
  assign if32.mem_ready    = d_mem_ready & ~sel;
  assign if32.mem_rvalid   = d_rvalid & ~sel;
  assign if32.mem_rdata    = d_rdata[31:0];
  assign if32.rsp_ready    = d_rsp_ready & ~sel;
  assign if64.req_valid    = d_req_valid & sel;
  assign if64.req_we       = d_we;
  assign if64.req_size     = d_size;
  assign if64.req_unsigned = d_uns;
  assign if64.req_addr     = d_addr;
  assign if64.req_wdata    = d_wdata;
  assign if64.mem_ready    = d_mem_ready & sel;
  assign if64.mem_rvalid   = d_rvalid & sel;
  assign if64.mem_rdata    = d_rdata;
  assign if64.rsp_ready    = d_rsp_ready & sel;

  logic        m_req_ready, m_mem_valid, m_mem_we, m_rsp_valid, m_rsp_err;
  logic [63:0] m_mem_addr, m_mem_wdata, m_rsp_data;
  logic [7:0]  m_mem_wstrb;
  assign m_req_ready = sel ? if64.req_ready : if32.req_ready;
  assign m_mem_valid = sel ? if64.mem_valid : if32.mem_valid;
  assign m_mem_we    = sel ? if64.mem_we    : if32.mem_we;
  assign m_mem_addr  = sel ? if64.mem_addr  : {32'h0, if32.mem_addr};
  assign m_mem_wdata = sel ? if64.mem_wdata : {32'h0, if32.mem_wdata};
  assign m_mem_wstrb = sel ? if64.mem_wstrb : {4'h0, if32.mem_wstrb};
  assign m_rsp_valid = sel ? if64.rsp_valid : if32.rsp_valid;
  assign m_rsp_data  = sel ? if64.rsp_data  : {32'h0, if32.rsp_data};
  assign m_rsp_err   = sel ? if64.rsp_err   : if32.rsp_err;

  typedef struct {
    bit          err;
    bit          we;
    logic [63:0] addr;
    logic [7:0]  strb;
    logic [63:0] wdata;
    logic [63:0] rsp;
  } exp_t;

  // Expected outcome of one op, straight from the byte-lane rules.
  function automatic exp_t model(input int unsigned w, input bit we, input int unsigned size,
                                 input bit uns, input logic [63:0] addr, input logic [63:0] wdata,
                                 input logic [63:0] rdata);
    exp_t e;
    int unsigned bytes, off;
    logic [63:0] wmask, lmask, v;
    bytes   = 1 << size;
    wmask   = (w == 64) ? '1 : 64'h0000_0000_FFFF_FFFF;
    off     = 32'(addr % 64'(w / 8));
    e.we    = we;
    e.err   = (size == 3 && w == 32) || ((addr % 64'(bytes)) != 0);
    e.addr  = addr - 64'(off);
    e.strb  = we ? 8'(((1 << bytes) - 1) << off) : 8'h00;
    e.wdata = (wdata << (8 * off)) & wmask;
    lmask   = (bytes == 8) ? '1 : (64'd1 << (8 * bytes)) - 64'd1;
    v       = (rdata >> (8 * off)) & lmask;
    if (!uns && v[8*bytes-1]) v = v | ~lmask;
    e.rsp   = (we || e.err) ? 64'd0 : (v & wmask);
    return e;
  endfunction

  int   n_checks = 0, n_fail = 0;
  int   cyc = 0, acc_cyc = 0, exp_lat = 0, phase = 0;
  bit   busy = 1'b0, seen_rsp = 1'b1, chk_en = 1'b0;
  exp_t cur;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic bail(input string name);
    check(name, 64'd0, 64'd1);
    finish_run();
  endtask

  // Phase: 0 idle, 1 memory request expected, 2 waiting for memory, 3 response expected.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("req_ready", 64'(m_req_ready), busy ? 64'd0 : 64'd1);
      check("mem_valid", 64'(m_mem_valid), 64'(phase == 1));
      check("rsp_valid", 64'(m_rsp_valid), 64'(phase == 3));
      if (m_mem_valid && phase == 1) begin
        check("mem_addr", m_mem_addr, cur.addr);
        check("mem_we", 64'(m_mem_we), 64'(cur.we));
        check("mem_wstrb", 64'(m_mem_wstrb), 64'(cur.strb));
        if (cur.we) check("mem_wdata", m_mem_wdata, cur.wdata);
      end
      if (m_rsp_valid && phase == 3) begin
        check("rsp_data", m_rsp_data, cur.rsp);
        check("rsp_err", 64'(m_rsp_err), 64'(cur.err));
        if (!seen_rsp) begin
          seen_rsp = 1'b1;
          check("latency", 64'(cyc - acc_cyc), 64'(exp_lat));
        end
      end
    end
  end

  task automatic do_op(input bit s64, input bit we, input int unsigned size, input bit uns,
                       input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] rdata,
                       input int unsigned mstall, input int unsigned rwait, input int unsigned rstall);
    logic [63:0] wm;
    int unsigned n;
    wm  = s64 ? '1 : 64'h0000_0000_FFFF_FFFF;
    sel = s64;
    cur = model(s64 ? 64 : 32, we, size, uns, addr & wm, wdata & wm, rdata & wm);
    d_we = we; d_size = 2'(size); d_uns = uns; d_addr = addr & wm; d_wdata = wdata & wm;
    d_req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!m_req_ready) begin
      if (n > 20) bail("accept_timeout");
      @(negedge clk); n++;
    end
    acc_cyc  = cyc;
    seen_rsp = 1'b0;
    exp_lat  = cur.err ? 1 : int'(3 + mstall + rwait);
    @(posedge clk); #1;
    d_req_valid = 1'b0; d_addr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom};
    d_size = 2'($urandom_range(0, 3)); d_we = 1'($urandom_range(0, 1));
    busy  = 1'b1;
    phase = cur.err ? 3 : 1;
    if (!cur.err) begin
      n = 0;
      d_mem_ready = (mstall == 0);
      forever begin
        @(negedge clk);
        if (m_mem_valid && d_mem_ready) break;
        if (n > 50) bail("mem_req_timeout");
        @(posedge clk); #1;
        n++;
        d_mem_ready = (n >= mstall);
        d_rvalid = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      d_mem_ready = 1'b0; d_rvalid = 1'b0; phase = 2;
      for (int unsigned i = 0; i < rwait; i++) begin
        @(posedge clk); #1;
      end
      d_rvalid = 1'b1; d_rdata = rdata & wm;
      @(posedge clk); #1;
      d_rvalid = 1'b0; d_rdata = {$urandom, $urandom}; phase = 3;
    end
    n = 0;
    d_rsp_ready = (rstall == 0);
    forever begin
      @(negedge clk);
      if (m_rsp_valid && d_rsp_ready) break;
      if (n > 50) bail("rsp_timeout");
      @(posedge clk); #1;
      n++;
      d_rsp_ready = (n >= rstall);
      d_rvalid = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    d_rsp_ready = 1'b0; d_rvalid = 1'b0; phase = 0; busy = 1'b0;
  endtask

  // Load abandoned by reset while waiting for memory; a late response must be dropped.
  task automatic reset_mid(input bit s64);
    sel = s64;
    cur = model(s64 ? 64 : 32, 1'b0, 2, 1'b0, 64'h40, 64'd0, 64'd0);
    d_we = 1'b0; d_size = 2'd2; d_uns = 1'b0; d_addr = 64'h40; d_req_valid = 1'b1;
    @(posedge clk); #1;
    d_req_valid = 1'b0; busy = 1'b1; phase = 1; d_mem_ready = 1'b1;
    @(posedge clk); #1;
    d_mem_ready = 1'b0; phase = 2;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; busy = 1'b0; phase = 0;
    d_rvalid = 1'b1; d_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    d_rvalid = 1'b0;
    @(negedge clk);
    check("rst_mid_rsp_data", m_rsp_data, 64'd0);
    check("rst_mid_rsp_err", 64'(m_rsp_err), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    bit          r_s64, r_we, r_uns;
    int unsigned r_size;
    logic [63:0] r_addr;

    e = model(32, 1'b1, 2, 1'b0, 64'h8000_0004, 64'hDEAD_BEEF, 64'd0);
    check("pin_sw_addr", e.addr, 64'h8000_0004);
    check("pin_sw_strb", 64'(e.strb), 64'h0F);
    check("pin_sw_wdata", e.wdata, 64'hDEAD_BEEF);
    e = model(32, 1'b1, 0, 1'b0, 64'h8000_0003, 64'hAB, 64'd0);
    check("pin_sb_strb", 64'(e.strb), 64'h08);
    check("pin_sb_wdata", e.wdata, 64'hAB00_0000);
    check("pin_sb_rsp", e.rsp, 64'd0);
    e = model(32, 1'b0, 0, 1'b0, 64'h8000_0002, 64'd0, 64'h0080_0000);
    check("pin_lb", e.rsp, 64'hFFFF_FF80);
    e = model(32, 1'b0, 0, 1'b1, 64'h8000_0002, 64'd0, 64'h0080_0000);
    check("pin_lbu", e.rsp, 64'h0000_0080);
    e = model(32, 1'b0, 2, 1'b0, 64'h8000_0002, 64'd0, 64'd0);
    check("pin_lw_misalign", 64'(e.err), 64'd1);
    e = model(64, 1'b0, 2, 1'b1, 64'h4, 64'd0, 64'hFFFF_FFFF_0000_0000);
    check("pin_lwu64", e.rsp, 64'h0000_0000_FFFF_FFFF);

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst32_req_ready", 64'(if32.req_ready), 64'd1);
    check("rst32_mem_valid", 64'(if32.mem_valid), 64'd0);
    check("rst32_rsp_valid", 64'(if32.rsp_valid), 64'd0);
    check("rst32_rsp_data", 64'(if32.rsp_data), 64'd0);
    check("rst32_rsp_err", 64'(if32.rsp_err), 64'd0);
    check("rst32_mem_addr", 64'(if32.mem_addr), 64'd0);
    check("rst64_req_ready", 64'(if64.req_ready), 64'd1);
    check("rst64_rsp_data", if64.rsp_data, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;

    do_op(1'b0, 1'b1, 2, 1'b0, 64'h8000_0004, 64'hDEAD_BEEF, 64'h1234, 0, 0, 0);
    do_op(1'b0, 1'b1, 0, 1'b0, 64'h8000_0003, 64'hAB, 64'h5555, 0, 0, 0);
    do_op(1'b0, 1'b0, 0, 1'b0, 64'h8000_0002, 64'd0, 64'h0080_0000, 0, 0, 0);
    do_op(1'b0, 1'b0, 0, 1'b1, 64'h8000_0002, 64'd0, 64'h0080_0000, 0, 0, 0);
    do_op(1'b0, 1'b0, 2, 1'b0, 64'h8000_0002, 64'd0, 64'hFFFF_FFFF, 0, 0, 0);
    do_op(1'b0, 1'b0, 3, 1'b0, 64'h8000_0000, 64'd0, 64'hFFFF_FFFF, 0, 0, 0);
    do_op(1'b0, 1'b1, 1, 1'b0, 64'h8000_1002, 64'h1234_BEEF, 64'd0, 3, 0, 2);
    do_op(1'b0, 1'b0, 1, 1'b0, 64'h8000_1002, 64'd0, 64'h8001_0000, 3, 1, 2);
    reset_mid(1'b0);
    do_op(1'b1, 1'b0, 3, 1'b0, 64'h8, 64'd0, 64'h8123_4567_89AB_CDEF, 0, 0, 0);
    do_op(1'b1, 1'b0, 2, 1'b1, 64'h4, 64'd0, 64'hFFFF_FFFF_0000_0000, 0, 0, 0);
    do_op(1'b1, 1'b0, 2, 1'b0, 64'h4, 64'd0, 64'hFFFF_FFFF_0000_0000, 1, 2, 1);
    do_op(1'b1, 1'b1, 1, 1'b0, 64'h16, 64'hCAFE, 64'd0, 0, 0, 0);
    do_op(1'b1, 1'b1, 3, 1'b0, 64'h4, 64'hCAFE, 64'd0, 0, 0, 0);
    reset_mid(1'b1);

    for (int k = 0; k < 400; k++) begin
      r_s64  = (k % 2) == 1;
      r_we   = 1'($urandom_range(0, 1));
      r_uns  = 1'($urandom_range(0, 1));
      r_size = $urandom_range(0, 3);
      r_addr = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~((64'd1 << r_size) - 64'd1);
      do_op(r_s64, r_we, r_size, r_uns, r_addr, {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    repeat (2) @(posedge clk);
    finish_run();
  end

endmodule
